// File: rtl/seg7_pkg.sv
// Shared constants and state type for the seven-segment scroll sequencer.
// Codes >= 16 are blanked by the downstream decoder; 16 is the canonical blank.
package seg7_pkg;

  localparam logic [4:0] BLANK     = 5'd16;
  localparam int         DIGITS    = 6;
  localparam int         BUF_DEPTH = 16;
  localparam logic [4:0] MAX_LEN   = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    STATIC,
    SCROLL
  } state_t;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/seg7_step_timer.sv
// Free-running step divider: one-cycle tick every STEP_CYCLES enabled cycles.
// Held at zero while disabled or cleared so every scroll run starts from a fresh count.
module seg7_step_timer #(
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Message sequencer feeding six static 7-seg digits: static view of the first six
// codes, or a scrolling window over the message followed by six blanks.
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic       wr_ready,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [4:0] msg_len,
  output logic       busy,
  output logic       wrap_pulse,
  output logic [4:0] num5,
  output logic [4:0] num4,
  output logic [4:0] num3,
  output logic [4:0] num2,
  output logic [4:0] num1,
  output logic [4:0] num0
);

  state_t     state;
  logic [4:0] buffer [BUF_DEPTH];
  logic [4:0] len_q;
  logic [4:0] pos;
  logic [4:0] n_total;
  logic       start_ok;
  logic       tick;
  logic [4:0] disp  [DIGITS];
  logic [4:0] num_q [DIGITS];

  assign start_ok = start && !stop && (msg_len != 5'd0);
  assign n_total  = len_q + 5'd6;
  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  seg7_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr    (start_ok || stop),
    .en     (state == SCROLL),
    .tick   (tick)
  );

  // Write and start may share an IDLE cycle; the write lands on the same edge the
  // state changes, so the first registered display already sees the new code.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      len_q      <= 5'd0;
      pos        <= 5'd0;
      wrap_pulse <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= BLANK;
    end else begin
      wrap_pulse <= 1'b0;
      if (wr_en && state == IDLE) buffer[wr_addr] <= wr_data;
      if (stop) begin
        state <= IDLE;
        pos   <= 5'd0;
      end else if (start_ok) begin
        state <= mode ? SCROLL : STATIC;
        len_q <= clamp_len(msg_len);
        pos   <= 5'd0;
      end else if (state == SCROLL && tick) begin
        if (pos == n_total - 5'd1) begin
          pos        <= 5'd0;
          wrap_pulse <= 1'b1;
        end else begin
          pos <= pos + 5'd1;
        end
      end
    end
  end

  // Static mode keeps pos at 0, so the same window logic serves both modes.
  // pos < N and k < 6 <= N, so a single conditional subtract replaces the modulo.
  always_comb begin
    logic [4:0] idx;
    for (int k = 0; k < DIGITS; k++) begin
      idx = pos + 5'(k);
      if (idx >= n_total) idx = idx - n_total;
      disp[k] = BLANK;
      if (state != IDLE && idx < len_q) disp[k] = buffer[idx[3:0]];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int j = 0; j < DIGITS; j++) num_q[j] <= BLANK;
    end else begin
      for (int k = 0; k < DIGITS; k++) num_q[DIGITS-1-k] <= disp[k];
    end
  end

  assign num5 = num_q[5];
  assign num4 = num_q[4];
  assign num3 = num_q[3];
  assign num2 = num_q[2];
  assign num1 = num_q[1];
  assign num0 = num_q[0];

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Directed bench for seg7_scroll_ctrl with a 4-cycle scroll step; expected digit
// windows are hand-derived from the message stream and scroll position.
module tb_seg7_scroll_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_ready;
  logic       start;
  logic       stop;
  logic       mode;
  logic [4:0] msg_len;
  logic       busy;
  logic       wrap_pulse;
  logic [4:0] num5, num4, num3, num2, num1, num0;
  logic [29:0] nums;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] B = 5'd16;

  seg7_scroll_ctrl #(.STEP_CYCLES(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .msg_len   (msg_len),
    .busy      (busy),
    .wrap_pulse(wrap_pulse),
    .num5      (num5),
    .num4      (num4),
    .num3      (num3),
    .num2      (num2),
    .num1      (num1),
    .num0      (num0)
  );

  always #5 sys_clk = ~sys_clk;

  assign nums = {num5, num4, num3, num2, num1, num0};

  function automatic logic [29:0] pack6(input logic [4:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [4:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [4:0] len);
    start = 1'b1; mode = m; msg_len = len;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'd5;
    start = 1'b0; stop = 1'b0; mode = 1'b0; msg_len = 5'd0;
    step(3);
    total++;
    if (nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL reset_nums: got %h want %h", nums, pack6(B, B, B, B, B, B));
    end
    total++;
    if ({wr_ready, busy, wrap_pulse} !== 3'b100) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 100", {wr_ready, busy, wrap_pulse});
    end
    sys_rst = 1'b0; wr_en = 1'b0;
    step(1);
    do_start(1'b0, 5'd6);
    step(1);
    total++;
    if (nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL reset_write_dropped: got %h want %h", nums, pack6(B, B, B, B, B, B));
    end
    do_stop();
  endtask

  task automatic test_readback();
    for (int i = 0; i < 6; i++) do_write(4'(i), 5'(i));
    do_start(1'b0, 5'd6);
    total++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL readback_busy: got busy=%b ready=%b want 1 0", busy, wr_ready);
    end
    step(1);
    total++;
    if (nums !== pack6(0, 1, 2, 3, 4, 5)) begin
      bad++; $display("[TB] FAIL readback_nums: got %h want %h", nums, pack6(0, 1, 2, 3, 4, 5));
    end
    do_stop();
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL stop_idle: got busy=%b ready=%b want 0 1", busy, wr_ready);
    end
    step(1);
    total++;
    if (nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL stop_blank: got %h want %h", nums, pack6(B, B, B, B, B, B));
    end
  endtask

  task automatic test_static();
    do_write(4'd0, 5'd1);
    do_write(4'd1, 5'd2);
    do_write(4'd2, 5'd3);
    do_start(1'b0, 5'd3);
    step(1);
    total++;
    if (nums !== pack6(1, 2, 3, B, B, B)) begin
      bad++; $display("[TB] FAIL static_len3: got %h want %h", nums, pack6(1, 2, 3, B, B, B));
    end
    step(8);
    total++;
    if (nums !== pack6(1, 2, 3, B, B, B) || wrap_pulse !== 1'b0) begin
      bad++; $display("[TB] FAIL static_hold: got %h wrap=%b want %h wrap=0", nums, wrap_pulse, pack6(1, 2, 3, B, B, B));
    end
    do_stop();
  endtask

  task automatic test_scroll();
    int wraps = 0;
    int wrap_at = -1;
    for (int i = 0; i < 6; i++) do_write(4'(i), 5'(10 + i));
    for (int i = 0; i < 4; i++) do_write(4'(6 + i), 5'(i));
    do_start(1'b1, 5'd10);
    for (int c = 1; c <= 70; c++) begin
      step(1);
      if (wrap_pulse === 1'b1) begin
        wraps++; wrap_at = c;
      end
      if (c == 1) begin
        total++;
        if (nums !== pack6(10, 11, 12, 13, 14, 15)) begin
          bad++; $display("[TB] FAIL scroll_pos0: got %h want %h", nums, pack6(10, 11, 12, 13, 14, 15));
        end
      end
      if (c == 5) begin
        total++;
        if (nums !== pack6(11, 12, 13, 14, 15, 0)) begin
          bad++; $display("[TB] FAIL scroll_pos1: got %h want %h", nums, pack6(11, 12, 13, 14, 15, 0));
        end
      end
      if (c == 37) begin
        total++;
        if (nums !== pack6(3, B, B, B, B, B)) begin
          bad++; $display("[TB] FAIL scroll_pos9: got %h want %h", nums, pack6(3, B, B, B, B, B));
        end
      end
      if (c == 57) begin
        total++;
        if (nums !== pack6(B, B, 10, 11, 12, 13)) begin
          bad++; $display("[TB] FAIL scroll_pos14: got %h want %h", nums, pack6(B, B, 10, 11, 12, 13));
        end
      end
      if (c == 65) begin
        total++;
        if (nums !== pack6(10, 11, 12, 13, 14, 15)) begin
          bad++; $display("[TB] FAIL scroll_wrapped: got %h want %h", nums, pack6(10, 11, 12, 13, 14, 15));
        end
      end
    end
    total++;
    if (wraps != 1 || wrap_at != 64) begin
      bad++; $display("[TB] FAIL scroll_wrap: got count=%0d at=%0d want count=1 at=64", wraps, wrap_at);
    end
  endtask

  task automatic test_write_drop();
    total++;
    if (wr_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL scroll_ready: got %b want 0", wr_ready);
    end
    do_write(4'd0, 5'd7);
    do_stop();
    do_start(1'b0, 5'd1);
    step(1);
    total++;
    if (nums !== pack6(10, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL write_dropped: got %h want %h", nums, pack6(10, B, B, B, B, B));
    end
  endtask

  task automatic test_stop_start();
    int wraps = 0;
    do_start(1'b1, 5'd10);
    step(6);
    stop = 1'b1; start = 1'b1; mode = 1'b1; msg_len = 5'd10;
    step(1);
    stop = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL stop_wins: got busy=%b ready=%b want 0 1", busy, wr_ready);
    end
    step(1);
    total++;
    if (nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL stop_wins_blank: got %h want %h", nums, pack6(B, B, B, B, B, B));
    end
    for (int c = 0; c < 70; c++) begin
      step(1);
      if (wrap_pulse === 1'b1) wraps++;
    end
    total++;
    if (wraps != 0) begin
      bad++; $display("[TB] FAIL stop_no_wrap: got %0d want 0", wraps);
    end
  endtask

  task automatic test_len_zero();
    do_start(1'b1, 5'd0);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL len0_idle: got busy=%b want 0", busy);
    end
    do_start(1'b0, 5'd0);
    step(1);
    total++;
    if (busy !== 1'b0 || nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL len0_blank: got busy=%b nums=%h want 0 %h", busy, nums, pack6(B, B, B, B, B, B));
    end
  endtask

  task automatic test_len_clamp();
    int wraps = 0;
    int wrap_at = -1;
    do_write(4'd15, 5'd9);
    do_start(1'b1, 5'd20);
    for (int c = 1; c <= 92; c++) begin
      step(1);
      if (wrap_pulse === 1'b1) begin
        wraps++; wrap_at = c;
      end
      if (c == 41) begin
        total++;
        if (nums !== pack6(B, B, B, B, B, 9)) begin
          bad++; $display("[TB] FAIL clamp_pos10: got %h want %h", nums, pack6(B, B, B, B, B, 9));
        end
      end
      if (c == 65) begin
        total++;
        if (nums !== pack6(B, B, B, B, B, B)) begin
          bad++; $display("[TB] FAIL clamp_pos16: got %h want %h", nums, pack6(B, B, B, B, B, B));
        end
      end
    end
    total++;
    if (wraps != 1 || wrap_at != 88) begin
      bad++; $display("[TB] FAIL clamp_wrap: got count=%0d at=%0d want count=1 at=88", wraps, wrap_at);
    end
  endtask

  task automatic test_reset_mid();
    total++;
    if (nums !== pack6(10, 11, 12, 13, 14, 15) || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL pre_reset: got %h busy=%b want %h busy=1", nums, busy, pack6(10, 11, 12, 13, 14, 15));
    end
    #2;
    sys_rst = 1'b1;
    #1;
    total++;
    if (nums !== pack6(B, B, B, B, B, B) || {wr_ready, busy, wrap_pulse} !== 3'b100) begin
      bad++; $display("[TB] FAIL async_reset: got %h flags=%b want %h flags=100", nums, {wr_ready, busy, wrap_pulse}, pack6(B, B, B, B, B, B));
    end
    step(1);
    sys_rst = 1'b0;
    do_start(1'b0, 5'd6);
    step(1);
    total++;
    if (nums !== pack6(B, B, B, B, B, B)) begin
      bad++; $display("[TB] FAIL reset_buffer_cleared: got %h want %h", nums, pack6(B, B, B, B, B, B));
    end
  endtask

  initial begin
    $display("[TB] starting seg7_scroll_ctrl bench");
    test_reset();
    test_readback();
    test_static();
    test_scroll();
    test_write_drop();
    test_stop_start();
    test_len_zero();
    test_len_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
